// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO with occupancy count, almost-full/empty
// flags and sticky overflow/underflow. Define SYNC_FIFO_HIGHWATER_EN to add `hwm`.
module sync_fifo #(
  parameter int unsigned Width       = 12,
  parameter int unsigned Size        = 4,
  parameter int unsigned AlmostFull  = Size - 1,
  parameter int unsigned AlmostEmpty = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w,
  input  logic [Width-1:0]      wd,
  output logic                  wfull,
  output logic                  afull,
  input  logic                  r,
  output logic [Width-1:0]      rd,
  output logic                  rempty,
  output logic                  aempty,
  output logic [$clog2(Size):0] count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  errclr
`ifdef SYNC_FIFO_HIGHWATER_EN
  ,
  output logic [$clog2(Size):0] hwm
`endif
);

  localparam int unsigned AW = $clog2(Size);
  localparam int unsigned CW = AW + 1;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t SizeC = cnt_t'(Size);
  localparam cnt_t AfC   = cnt_t'(AlmostFull);
  localparam cnt_t AeC   = cnt_t'(AlmostEmpty);

  logic [Width-1:0] mem [Size];

  ptr_t wptr_q, wptr_d;
  ptr_t rptr_q, rptr_d;
  cnt_t count_q, count_d;
  logic wfull_q, wfull_d;
  logic rempty_q, rempty_d;
  logic afull_q, afull_d;
  logic aempty_q, aempty_d;
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;
  logic rdo, wdo;

  always_comb begin
    rdo = r & ~rempty_q;
    wdo = w & (~wfull_q | r);

    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wdo) wptr_d = wptr_q + ptr_t'(1);
    if (rdo) rptr_d = rptr_q + ptr_t'(1);
    unique case ({wdo, rdo})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase

    wfull_d  = (count_d == SizeC);
    rempty_d = (count_d == '0);
    afull_d  = (count_d >= AfC);
    aempty_d = (count_d <= AeC);

    // A read paired with a write on an empty FIFO is not an underflow; the
    // write lands and the read is simply not performed, mirroring overflow.
    ovf_d = (w & wfull_q & ~r) | (ovf_q & ~errclr);
    unf_d = (r & rempty_q & ~w) | (unf_q & ~errclr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      wfull_q  <= 1'b0;
      rempty_q <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      wfull_q  <= wfull_d;
      rempty_q <= rempty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wdo) mem[wptr_q] <= wd;
  end

  assign rd        = mem[rptr_q];
  assign count     = count_q;
  assign wfull     = wfull_q;
  assign rempty    = rempty_q;
  assign afull     = afull_q;
  assign aempty    = aempty_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

`ifdef SYNC_FIFO_HIGHWATER_EN
  cnt_t hwm_q, hwm_d;

  always_comb begin
    hwm_d = hwm_q;
    if (errclr)                 hwm_d = count_d;
    else if (count_d > hwm_q)   hwm_d = count_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hwm_q <= '0;
    else        hwm_q <= hwm_d;
  end

  assign hwm = hwm_q;
`endif

endmodule
